param_alu_pipe: RTL and testbench

- Parametrised, registered successor to the 8-bit combinational ALU, keeping the same 16-operation encoding.
- Adds a valid/ready handshake, one output register stage, status flags (carry, zero, negative, overflow) and an internal accumulator that can replace operand A.
- Sits between a command source (sequencer or CPU datapath) and a result consumer that may apply backpressure.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_core.sv | 58 +++++
 rtl/param_alu_pipe.sv | 93 +++++++++
 tb/tb_param_alu_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings and flag bit positions for param_alu_pipe
package alu_pkg;

    localparam logic [3:0] OP_PASS_A = 4'b0000;
    localparam logic [3:0] OP_INC_A  = 4'b0001;
    localparam logic [3:0] OP_DEC_A  = 4'b0010;
    localparam logic [3:0] OP_PASS_B = 4'b0011;
    localparam logic [3:0] OP_INC_B  = 4'b0100;
    localparam logic [3:0] OP_DEC_B  = 4'b0101;
    localparam logic [3:0] OP_ADD    = 4'b0110;
    localparam logic [3:0] OP_ADC    = 4'b0111;
    localparam logic [3:0] OP_NOT_A  = 4'b1000;
    localparam logic [3:0] OP_NOT_B  = 4'b1001;
    localparam logic [3:0] OP_AND    = 4'b1010;
    localparam logic [3:0] OP_OR     = 4'b1011;
    localparam logic [3:0] OP_NAND   = 4'b1100;
    localparam logic [3:0] OP_NOR    = 4'b1101;
    localparam logic [3:0] OP_XOR    = 4'b1110;
    localparam logic [3:0] OP_XNOR   = 4'b1111;

    // Bit positions inside the registered flag vector
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int FLAG_W = 4;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational W-bit ALU datapath
// Ports: op_a, b, c_in, sel in; y_next, carry_next, ovf_next out.
module alu_core #(
    parameter int W = 8
) (
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    input  logic [3:0]   sel,
    output logic [W-1:0] y_next,
    output logic         carry_next,
    output logic         ovf_next
);
    import alu_pkg::*;

    logic [W-1:0] add_x;
    logic [W-1:0] add_y;
    logic         add_ci;
    logic         is_arith;
    logic [W-1:0] logic_res;
    logic [W:0]   sum;

    // Every arithmetic op is a single W+1 bit add; decrement adds all-ones
    // so carry drops only when the operand was zero.
    always_comb begin
        add_x     = '0;
        add_y     = '0;
        add_ci    = 1'b0;
        is_arith  = 1'b1;
        logic_res = '0;
        case (sel)
            OP_INC_A: begin add_x = op_a; add_y = {{(W-1){1'b0}}, 1'b1}; end
            OP_DEC_A: begin add_x = op_a; add_y = '1; end
            OP_INC_B: begin add_x = b;    add_y = {{(W-1){1'b0}}, 1'b1}; end
            OP_DEC_B: begin add_x = b;    add_y = '1; end
            OP_ADD:   begin add_x = op_a; add_y = b; end
            OP_ADC:   begin add_x = op_a; add_y = b; add_ci = c_in; end
            OP_PASS_A: begin is_arith = 1'b0; logic_res = op_a; end
            OP_PASS_B: begin is_arith = 1'b0; logic_res = b; end
            OP_NOT_A:  begin is_arith = 1'b0; logic_res = ~op_a; end
            OP_NOT_B:  begin is_arith = 1'b0; logic_res = ~b; end
            OP_AND:    begin is_arith = 1'b0; logic_res = op_a & b; end
            OP_OR:     begin is_arith = 1'b0; logic_res = op_a | b; end
            OP_NAND:   begin is_arith = 1'b0; logic_res = ~(op_a & b); end
            OP_NOR:    begin is_arith = 1'b0; logic_res = ~(op_a | b); end
            OP_XOR:    begin is_arith = 1'b0; logic_res = op_a ^ b; end
            OP_XNOR:   begin is_arith = 1'b0; logic_res = ~(op_a ^ b); end
            default:   begin is_arith = 1'b0; end
        endcase
    end

    assign sum        = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_ci};
    assign y_next     = is_arith ? sum[W-1:0] : logic_res;
    assign carry_next = is_arith & sum[W];
    // Signed overflow: addends agree in sign, result disagrees
    assign ovf_next   = is_arith & (add_x[W-1] == add_y[W-1]) & (sum[W-1] != add_x[W-1]);

endmodule

// File: rtl/param_alu_pipe.sv
// rtl/param_alu_pipe.sv - registered ALU with handshake, flags and accumulator
// Ports: clk, rst_n; in_valid/in_ready command side with a, b, c_in, sel,
// use_acc, acc_clr; out_valid/out_ready result side with y, carry, zero,
// neg, ovf; acc_out shows the accumulator.
module param_alu_pipe #(
    parameter int W      = 8,
    parameter int ACC_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    input  logic [3:0]   sel,
    input  logic         use_acc,
    input  logic         acc_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         carry,
    output logic         zero,
    output logic         neg,
    output logic         ovf,
    output logic [W-1:0] acc_out
);
    import alu_pkg::*;

    logic [W-1:0]      acc;
    logic [W-1:0]      op_a;
    logic [W-1:0]      y_next;
    logic              carry_next;
    logic              ovf_next;
    logic              accept;
    logic [FLAG_W-1:0] flags;
    logic [FLAG_W-1:0] flags_next;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign op_a     = ((ACC_EN != 0) && use_acc) ? acc : a;

    alu_core #(.W(W)) u_core (
        .op_a       (op_a),
        .b          (b),
        .c_in       (c_in),
        .sel        (sel),
        .y_next     (y_next),
        .carry_next (carry_next),
        .ovf_next   (ovf_next)
    );

    always_comb begin
        flags_next         = '0;
        flags_next[FLAG_C] = carry_next;
        flags_next[FLAG_Z] = (y_next == '0);
        flags_next[FLAG_N] = y_next[W-1];
        flags_next[FLAG_V] = ovf_next;
    end

    // Result and flags only move on acceptance, so they stay frozen while
    // the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            flags     <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y         <= y_next;
            flags     <= flags_next;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Clear wins over update; a same-cycle use_acc command already read the
    // old value through op_a.
    always_ff @(posedge clk) begin
        if (!rst_n || (ACC_EN == 0) || acc_clr) begin
            acc <= '0;
        end else if (accept) begin
            acc <= y_next;
        end
    end

    assign carry   = flags[FLAG_C];
    assign zero    = flags[FLAG_Z];
    assign neg     = flags[FLAG_N];
    assign ovf     = flags[FLAG_V];
    assign acc_out = acc;

endmodule

// File: tb/tb_param_alu_pipe.sv
// tb/tb_param_alu_pipe.sv - self-checking bench for param_alu_pipe
module tb_param_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       c_in = 1'b0;
    logic [3:0] sel = 4'h0;
    logic       use_acc = 1'b0;
    logic       acc_clr = 1'b0;
    logic       out_ready = 1'b1;

    // index 0: ACC_EN=1 build, index 1: ACC_EN=0 build
    logic       in_ready_o [2];
    logic       out_valid_o [2];
    logic [7:0] y_o [2];
    logic       carry_o [2];
    logic       zero_o [2];
    logic       neg_o [2];
    logic       ovf_o [2];
    logic [7:0] acc_o [2];

    int n_chk = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    param_alu_pipe #(.W(8), .ACC_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[0]),
        .a(a), .b(b), .c_in(c_in), .sel(sel), .use_acc(use_acc), .acc_clr(acc_clr),
        .out_valid(out_valid_o[0]), .out_ready(out_ready), .y(y_o[0]),
        .carry(carry_o[0]), .zero(zero_o[0]), .neg(neg_o[0]), .ovf(ovf_o[0]),
        .acc_out(acc_o[0])
    );

    param_alu_pipe #(.W(8), .ACC_EN(0)) dut_noacc (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_o[1]),
        .a(a), .b(b), .c_in(c_in), .sel(sel), .use_acc(use_acc), .acc_clr(acc_clr),
        .out_valid(out_valid_o[1]), .out_ready(out_ready), .y(y_o[1]),
        .carry(carry_o[1]), .zero(zero_o[1]), .neg(neg_o[1]), .ovf(ovf_o[1]),
        .acc_out(acc_o[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on plain integers: returns {ovf, carry, y[7:0]}
    function automatic logic [9:0] golden(input logic [3:0] s, input int x, input int bb, input int ci);
        int r;
        int sr;
        int sx;
        int sb;
        bit c;
        bit v;
        sx = (x > 127) ? x - 256 : x;
        sb = (bb > 127) ? bb - 256 : bb;
        c = 1'b0;
        v = 1'b0;
        sr = 0;
        case (s)
            4'd0:  r = x;
            4'd1:  begin r = x + 1;       sr = sx + 1;       c = (r > 255); v = (sr > 127); end
            4'd2:  begin r = x - 1;       sr = sx - 1;       c = (x != 0);  v = (sr < -128); end
            4'd3:  r = bb;
            4'd4:  begin r = bb + 1;      sr = sb + 1;       c = (r > 255); v = (sr > 127); end
            4'd5:  begin r = bb - 1;      sr = sb - 1;       c = (bb != 0); v = (sr < -128); end
            4'd6:  begin r = x + bb;      sr = sx + sb;      c = (r > 255); v = (sr > 127) || (sr < -128); end
            4'd7:  begin r = x + bb + ci; sr = sx + sb + ci; c = (r > 255); v = (sr > 127) || (sr < -128); end
            4'd8:  r = 255 - x;
            4'd9:  r = 255 - bb;
            4'd10: r = x & bb;
            4'd11: r = x | bb;
            4'd12: r = 255 - (x & bb);
            4'd13: r = 255 - (x | bb);
            4'd14: r = x ^ bb;
            default: r = 255 - (x ^ bb);
        endcase
        return {v, c, 8'(r & 255)};
    endfunction

    // Transaction-level model of both builds
    bit  m_valid [2];
    int  m_y [2];
    bit  m_c [2];
    bit  m_v [2];
    int  m_acc [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit rdy;
            bit acc_now;
            int opa;
            logic [9:0] g;
            if (!rst_n) begin
                m_valid[k] = 0; m_y[k] = 0; m_c[k] = 0; m_v[k] = 0; m_acc[k] = 0;
                check_en = 1'b1;
            end else begin
                rdy = !m_valid[k] || out_ready;
                acc_now = (k == 0) && use_acc;
                opa = acc_now ? m_acc[k] : int'(a);
                g = golden(sel, opa, int'(b), int'(c_in));
                if (in_valid && rdy) begin
                    m_valid[k] = 1; m_y[k] = int'(g[7:0]); m_c[k] = g[8]; m_v[k] = g[9];
                end else if (out_ready) begin
                    m_valid[k] = 0;
                end
                if (k == 1 || acc_clr) m_acc[k] = 0;
                else if (in_valid && rdy) m_acc[k] = int'(g[7:0]);
            end
        end
    end

    // Per-cycle comparison away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("m%0d out_valid", k), out_valid_o[k], m_valid[k]);
                chk($sformatf("m%0d in_ready", k), in_ready_o[k], !m_valid[k] || out_ready);
                chk($sformatf("m%0d acc_out", k), acc_o[k], m_acc[k]);
                if (m_valid[k]) begin
                    chk($sformatf("m%0d y", k), y_o[k], m_y[k]);
                    chk($sformatf("m%0d carry", k), carry_o[k], m_c[k]);
                    chk($sformatf("m%0d ovf", k), ovf_o[k], m_v[k]);
                    chk($sformatf("m%0d zero", k), zero_o[k], m_y[k] == 0);
                    chk($sformatf("m%0d neg", k), neg_o[k], m_y[k] >= 128);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    logic [7:0] sweep_exp [16] = '{8'hA5, 8'hA6, 8'hA4, 8'hF0, 8'hF1, 8'hEF, 8'h95, 8'h96,
                                   8'h5A, 8'h0F, 8'hA0, 8'hF5, 8'h5F, 8'h0A, 8'h55, 8'hAA};

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset out_valid", out_valid_o[0], 0);
        chk("reset y", y_o[0], 0);
        chk("reset flags", {carry_o[0], zero_o[0], neg_o[0], ovf_o[0]}, 0);
        chk("reset acc", acc_o[0], 0);
        rst_n = 1'b1;
        #1;
        chk("reset in_ready", in_ready_o[0], 1);

        // 1: opcode sweep
        in_valid = 1'b1; a = 8'hA5; b = 8'hF0; c_in = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sel = 4'(i);
            tick();
            chk($sformatf("sweep sel%0d y", i), y_o[0], sweep_exp[i]);
            if (i == 6) begin
                chk("add carry", carry_o[0], 1);
                chk("add ovf", ovf_o[0], 0);
                chk("add neg", neg_o[0], 1);
            end
        end

        // 2: boundaries
        a = 8'h7F; sel = 4'd1; tick();
        chk("7F+1 y", y_o[0], 8'h80); chk("7F+1 ovf", ovf_o[0], 1);
        chk("7F+1 neg", neg_o[0], 1); chk("7F+1 carry", carry_o[0], 0);
        a = 8'h00; sel = 4'd2; tick();
        chk("00-1 y", y_o[0], 8'hFF); chk("00-1 carry", carry_o[0], 0); chk("00-1 ovf", ovf_o[0], 0);
        a = 8'hFF; sel = 4'd1; tick();
        chk("FF+1 y", y_o[0], 8'h00); chk("FF+1 zero", zero_o[0], 1); chk("FF+1 carry", carry_o[0], 1);

        // 3: backpressure
        a = 8'h10; sel = 4'd0; tick();
        chk("bp first y", y_o[0], 8'h10);
        out_ready = 1'b0; a = 8'h20;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp in_ready", in_ready_o[0], 0);
            chk("bp y hold", y_o[0], 8'h10);
            chk("bp valid hold", out_valid_o[0], 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", in_ready_o[0], 1);
        tick();
        chk("bp next y", y_o[0], 8'h20);

        // 4: accumulator
        in_valid = 1'b0; acc_clr = 1'b1; tick();
        chk("acc cleared", acc_o[0], 0);
        acc_clr = 1'b0; in_valid = 1'b1; use_acc = 1'b1; b = 8'h01; sel = 4'd6; a = 8'h77;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("acc chain y", y_o[0], i);
        end
        chk("acc value", acc_o[0], 8'h03);
        acc_clr = 1'b1; tick();
        chk("acc clr+use y", y_o[0], 8'h04);
        chk("acc clr+use acc", acc_o[0], 8'h00);
        acc_clr = 1'b0; use_acc = 1'b0;

        // 5: reset mid-operation
        a = 8'h3C; sel = 4'd0; tick();
        chk("pre-reset acc", acc_o[0], 8'h3C);
        chk("pre-reset valid", out_valid_o[0], 1);
        in_valid = 1'b0; rst_n = 1'b0; tick();
        chk("mid reset valid", out_valid_o[0], 0);
        chk("mid reset flags", {carry_o[0], zero_o[0], neg_o[0], ovf_o[0]}, 0);
        chk("mid reset acc", acc_o[0], 0);
        rst_n = 1'b1; tick();
        chk("post reset in_ready", in_ready_o[0], 1);

        // 6: ACC_EN=0 build ignores use_acc
        in_valid = 1'b1; use_acc = 1'b1; a = 8'h12; b = 8'h01; sel = 4'd6; tick();
        chk("noacc y", y_o[1], 8'h13);
        chk("noacc acc", acc_o[1], 8'h00);
        in_valid = 1'b0; use_acc = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
